// File: rtl/w_order_scheduler_pkg.sv
// Shared types for the AXI switch W-path scheduler: the AW order queue entry and the
// scheduler FSM state.
package w_order_scheduler_pkg;

    // Entry fields are sized for up to 16 masters/slaves; narrower switches zero-extend.
    localparam int unsigned SchedSrcW = 4;
    localparam int unsigned SchedDstW = 4;

    typedef struct packed {
        logic [SchedSrcW-1:0] src;
        logic [SchedDstW-1:0] dst;
        logic [7:0]           len;
    } w_sched_entry_t;

    typedef enum logic {
        StIdle,
        StBurst
    } w_sched_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy, exposing the head and the entry behind it.
// Depth must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4,
    parameter int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [Width-1:0] data_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [AddrW:0]   count_o,
    output logic [Width-1:0] head_o,
    output logic [Width-1:0] next_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [AddrW-1:0] rptr_q;
    logic [AddrW-1:0] wptr_q;
    logic [AddrW:0]   cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (cnt_q == (AddrW + 1)'(Depth));
    assign empty_o = (cnt_q == '0);
    assign do_pop  = pop_i & ~empty_o;
    // A pop frees the head slot this cycle, so a push alongside it is accepted even when full.
    assign do_push = push_i & (~full_o | do_pop);
    assign count_o = cnt_q;
    assign head_o  = mem_q[rptr_q];
    assign next_o  = mem_q[rptr_q + AddrW'(1)];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rptr_q <= '0;
            wptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + AddrW'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + AddrW'(1);
            end
            if (do_push && !do_pop) begin
                cnt_q <= cnt_q + (AddrW + 1)'(1);
            end else if (do_pop && !do_push) begin
                cnt_q <= cnt_q - (AddrW + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/w_order_scheduler.sv
// W-path scheduler: queues AW grants in order and steers the shared W bus to one master at a
// time, closing each burst on the beat count or WLAST.
module w_order_scheduler
    import w_order_scheduler_pkg::*;
#(
    parameter int unsigned N     = 2,
    parameter int unsigned M     = 2,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned LOG_N = (N > 1) ? $clog2(N) : 1,
    parameter int unsigned LOG_M = (M > 1) ? $clog2(M) : 1,
    parameter int unsigned LOG_D = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             awPush_i,
    input  logic [LOG_N-1:0] awSrc_i,
    input  logic [LOG_M-1:0] awDst_i,
    input  logic [7:0]       awLen_i,
    output logic             awFull_o,
    input  logic [N-1:0]     wVld_i,
    input  logic [N-1:0]     wLast_i,
    output logic [N-1:0]     wGrant_o,
    output logic [N-1:0]     busWVld_o,
    input  logic             busWRdy_i,
    output logic [LOG_N-1:0] busWSrc_o,
    output logic [LOG_M-1:0] busWDst_o,
    output logic [LOG_D:0]   outstanding_o,
    output logic             protErr_o
);

    localparam int unsigned EntryW = $bits(w_sched_entry_t);

    w_sched_state_e   state_q, state_d;
    logic [LOG_N-1:0] src_q, src_d;
    logic [LOG_M-1:0] dst_q, dst_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             perr_q, perr_d;

    w_sched_entry_t aw_entry;
    w_sched_entry_t head_entry;
    w_sched_entry_t next_entry;
    w_sched_entry_t load_entry;
    logic           fifo_full;
    logic           fifo_empty;
    logic [LOG_D:0] fifo_cnt;
    logic           pop;
    logic           load;
    logic           beat;
    logic           burst_end;
    logic           cnt_zero;
    logic           last;
    logic           unused_entry_hi;

    assign aw_entry = '{src: SchedSrcW'(awSrc_i), dst: SchedDstW'(awDst_i), len: awLen_i};
    assign unused_entry_hi = ^{load_entry.src, load_entry.dst};

    sync_fifo #(
        .Width(EntryW),
        .Depth(DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rstn   (rstn),
        .push_i (awPush_i),
        .pop_i  (pop),
        .data_i (aw_entry),
        .full_o (fifo_full),
        .empty_o(fifo_empty),
        .count_o(fifo_cnt),
        .head_o (head_entry),
        .next_o (next_entry)
    );

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        dst_d      = dst_q;
        cnt_d      = cnt_q;
        pop        = 1'b0;
        load       = 1'b0;
        load_entry = head_entry;
        beat       = 1'b0;
        burst_end  = 1'b0;
        cnt_zero   = (cnt_q == 8'd0);
        last       = wLast_i[src_q];
        wGrant_o   = '0;
        busWVld_o  = '0;
        busWSrc_o  = '0;
        busWDst_o  = '0;

        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    load    = 1'b1;
                    state_d = StBurst;
                end
            end
            StBurst: begin
                wGrant_o[src_q]  = 1'b1;
                busWVld_o[src_q] = wVld_i[src_q];
                busWSrc_o        = src_q;
                busWDst_o        = dst_q;
                beat             = wVld_i[src_q] & busWRdy_i;
                burst_end        = beat & (cnt_zero | last);
                if (burst_end) begin
                    pop = 1'b1;
                    // Chain straight into the following burst, which may be arriving right now.
                    if (fifo_cnt > (LOG_D + 1)'(1)) begin
                        load       = 1'b1;
                        load_entry = next_entry;
                    end else if (awPush_i) begin
                        load       = 1'b1;
                        load_entry = aw_entry;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (beat) begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (load) begin
            src_d = LOG_N'(load_entry.src);
            dst_d = LOG_M'(load_entry.dst);
            cnt_d = load_entry.len;
        end

        perr_d = (burst_end & (cnt_zero ^ last)) | (awPush_i & fifo_full & ~pop);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            perr_q  <= perr_d;
        end
    end

    assign awFull_o      = fifo_full;
    assign outstanding_o = fifo_cnt;
    assign protErr_o     = perr_q;

endmodule

// File: tb/tb_w_order_scheduler.sv
// Bench for w_order_scheduler: directed scenarios plus random traffic, all checked every cycle
// against a queue-based model of the AW order list and the active burst.
module tb_w_order_scheduler;

    localparam int N     = 2;
    localparam int M     = 2;
    localparam int DEPTH = 4;
    localparam int LOG_N = 1;
    localparam int LOG_M = 1;
    localparam int LOG_D = 2;

    logic             clk = 1'b0;
    logic             rstn;
    logic             awPush;
    logic [LOG_N-1:0] awSrc;
    logic [LOG_M-1:0] awDst;
    logic [7:0]       awLen;
    logic             awFull;
    logic [N-1:0]     wVld;
    logic [N-1:0]     wLast;
    logic [N-1:0]     wGrant;
    logic [N-1:0]     busWVld;
    logic             busWRdy;
    logic [LOG_N-1:0] busWSrc;
    logic [LOG_M-1:0] busWDst;
    logic [LOG_D:0]   outstanding;
    logic             protErr;

    always #5 clk = ~clk;

    w_order_scheduler #(
        .N    (N),
        .M    (M),
        .DEPTH(DEPTH)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .awPush_i     (awPush),
        .awSrc_i      (awSrc),
        .awDst_i      (awDst),
        .awLen_i      (awLen),
        .awFull_o     (awFull),
        .wVld_i       (wVld),
        .wLast_i      (wLast),
        .wGrant_o     (wGrant),
        .busWVld_o    (busWVld),
        .busWRdy_i    (busWRdy),
        .busWSrc_o    (busWSrc),
        .busWDst_o    (busWDst),
        .outstanding_o(outstanding),
        .protErr_o    (protErr)
    );

    typedef struct {
        int src;
        int dst;
        int len;
    } ent_t;

    // Model: ordered list of accepted AWs; the front one is being served while m_act is set,
    // with m_rem beats still owed to it.
    ent_t mq[$];
    bit   m_act;
    int   m_rem;
    bit   m_perr;
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_act  = 1'b0;
        m_rem  = 0;
        m_perr = 1'b0;
    endtask

    task automatic model_step();
        int s;
        bit beat;
        bit fin;
        bit acc;
        int old_size;
        s    = 0;
        beat = 1'b0;
        fin  = 1'b0;
        if (m_act) begin
            s    = mq[0].src;
            beat = wVld[s] && busWRdy;
            fin  = beat && (m_rem == 1 || wLast[s]);
        end
        old_size = mq.size();
        acc      = awPush && (old_size < DEPTH || fin);
        m_perr   = (fin && ((m_rem == 1) != wLast[s])) || (awPush && !acc);
        if (beat && !fin) m_rem--;
        if (fin) void'(mq.pop_front());
        if (acc) mq.push_back('{int'(awSrc), int'(awDst), int'(awLen)});
        if (fin) begin
            m_act = (mq.size() > 0);
            if (m_act) m_rem = mq[0].len + 1;
        end else if (!m_act && old_size > 0) begin
            m_act = 1'b1;
            m_rem = mq[0].len + 1;
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        logic [N-1:0] eg;
        logic [N-1:0] ev;
        int           es;
        int           ed;
        eg = '0;
        ev = '0;
        es = 0;
        ed = 0;
        if (m_act) begin
            es     = mq[0].src;
            ed     = mq[0].dst;
            eg[es] = 1'b1;
            ev[es] = wVld[es];
        end
        chk("wGrant", 32'(wGrant), 32'(eg));
        chk("busWVld", 32'(busWVld), 32'(ev));
        chk("busWSrc", 32'(busWSrc), 32'(es));
        chk("busWDst", 32'(busWDst), 32'(ed));
        chk("outstanding", 32'(outstanding), 32'(mq.size()));
        chk("awFull", 32'(awFull), 32'(mq.size() == DEPTH));
        chk("protErr", 32'(protErr), 32'(m_perr));
    end

    task automatic tick();
        @(posedge clk);
        if (rstn) model_step();
        #1;
    endtask

    task automatic idle_in();
        awPush  = 1'b0;
        awSrc   = '0;
        awDst   = '0;
        awLen   = '0;
        wVld    = '0;
        wLast   = '0;
        busWRdy = 1'b0;
    endtask

    task automatic push(input int s, input int d, input int l);
        awPush = 1'b1;
        awSrc  = LOG_N'(s);
        awDst  = LOG_M'(d);
        awLen  = 8'(l);
    endtask

    // Correct WLAST for the burst being served.
    task automatic set_last();
        wLast = '0;
        if (m_act && m_rem == 1) wLast[mq[0].src] = 1'b1;
    endtask

    logic [N-1:0] g [10];
    int           nb;
    int           perr_cnt;
    bit           done;
    int           ps [3] = '{0, 1, 0};
    int           pl [3] = '{0, 1, 0};

    initial begin
        idle_in();
        rstn = 1'b1;
        model_reset();
        #1 rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        #2;
        chk("rst_awFull", 32'(awFull), 32'd0);
        chk("rst_wGrant", 32'(wGrant), 32'd0);
        chk("rst_outstanding", 32'(outstanding), 32'd0);
        chk("rst_protErr", 32'(protErr), 32'd0);

        // Single burst: src1 dst0 len3, four beats.
        push(1, 0, 3);
        tick();
        awPush = 1'b0;
        #2;
        chk("sb_out_t1", 32'(outstanding), 32'd1);
        chk("sb_grant_t1", 32'(wGrant), 32'd0);
        tick();
        wVld    = 2'b10;
        busWRdy = 1'b1;
        for (int b = 1; b <= 4; b++) begin
            wLast = (b == 4) ? 2'b10 : 2'b00;
            #2;
            chk("sb_grant", 32'(wGrant), 32'b10);
            tick();
        end
        idle_in();
        #2;
        chk("sb_out_end", 32'(outstanding), 32'd0);
        chk("sb_perr", 32'(protErr), 32'd0);
        chk("sb_grant_end", 32'(wGrant), 32'd0);
        tick();

        // Ordering: three back-to-back AWs must be served 0,1,0 with no gap.
        wVld    = 2'b11;
        busWRdy = 1'b1;
        for (int c = 0; c < 7; c++) begin
            if (c < 3) push(ps[c], c % 2, pl[c]);
            else awPush = 1'b0;
            set_last();
            #2;
            g[c] = wGrant;
            tick();
        end
        chk("ord_g1", 32'(g[1]), 32'b00);
        chk("ord_g2", 32'(g[2]), 32'b01);
        chk("ord_g3", 32'(g[3]), 32'b10);
        chk("ord_g4", 32'(g[4]), 32'b10);
        chk("ord_g5", 32'(g[5]), 32'b01);
        chk("ord_g6", 32'(g[6]), 32'b00);
        idle_in();

        // Backpressure: len7 with ready toggling; only accepted beats count.
        push(0, 0, 7);
        tick();
        awPush = 1'b0;
        wVld   = 2'b01;
        nb     = 0;
        done   = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            busWRdy = c[0];
            set_last();
            #2;
            if (wGrant == 2'b01 && busWRdy) nb++;
            tick();
            if (outstanding == 0 && nb > 0) done = 1'b1;
        end
        chk("bp_done", 32'(done), 32'd1);
        chk("bp_beats", 32'(nb), 32'd8);
        idle_in();
        tick();

        // Mismatch: len3 ended early by WLAST on beat 2, then the next entry follows.
        wVld     = 2'b11;
        busWRdy  = 1'b1;
        perr_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            if (c == 0) push(1, 0, 3);
            else if (c == 1) push(0, 1, 0);
            else awPush = 1'b0;
            set_last();
            if (m_act && mq[0].src == 1 && m_rem == 3) wLast[1] = 1'b1;
            #2;
            g[c] = wGrant;
            perr_cnt += int'(protErr);
            if (c == 4) chk("mm_perr_c4", 32'(protErr), 32'd1);
            tick();
        end
        chk("mm_g2", 32'(g[2]), 32'b10);
        chk("mm_g3", 32'(g[3]), 32'b10);
        chk("mm_g4", 32'(g[4]), 32'b01);
        chk("mm_g5", 32'(g[5]), 32'b00);
        chk("mm_perr_cnt", 32'(perr_cnt), 32'd1);
        idle_in();
        tick();

        // Full: four pushes with no W traffic, a dropped fifth, then push+pop at full.
        for (int c = 0; c < 4; c++) begin
            push(c % 2, 0, 0);
            tick();
        end
        awPush = 1'b0;
        #2;
        chk("full_awFull", 32'(awFull), 32'd1);
        chk("full_out", 32'(outstanding), 32'd4);
        push(1, 1, 2);
        tick();
        awPush = 1'b0;
        #2;
        chk("full_drop_perr", 32'(protErr), 32'd1);
        chk("full_drop_out", 32'(outstanding), 32'd4);
        tick();
        push(1, 1, 0);
        wVld    = 2'b01;
        busWRdy = 1'b1;
        set_last();
        tick();
        idle_in();
        #2;
        chk("full_pp_out", 32'(outstanding), 32'd4);
        chk("full_pp_perr", 32'(protErr), 32'd0);
        wVld    = 2'b11;
        busWRdy = 1'b1;
        done    = 1'b0;
        for (int c = 0; c < 30 && !done; c++) begin
            set_last();
            tick();
            if (outstanding == 0) done = 1'b1;
        end
        chk("full_drain", 32'(done), 32'd1);
        idle_in();
        tick();

        // Reset during beat 2 of a len3 burst.
        push(0, 1, 3);
        tick();
        awPush = 1'b0;
        tick();
        wVld    = 2'b01;
        busWRdy = 1'b1;
        tick();
        rstn = 1'b0;
        model_reset();
        #1;
        chk("rst_mid_grant", 32'(wGrant), 32'd0);
        chk("rst_mid_busWVld", 32'(busWVld), 32'd0);
        chk("rst_mid_dst", 32'(busWDst), 32'd0);
        chk("rst_mid_out", 32'(outstanding), 32'd0);
        idle_in();
        #1 rstn = 1'b1;
        tick();
        push(1, 1, 0);
        tick();
        awPush = 1'b0;
        tick();
        wVld    = 2'b10;
        busWRdy = 1'b1;
        set_last();
        #2;
        chk("post_rst_grant", 32'(wGrant), 32'b10);
        chk("post_rst_dst", 32'(busWDst), 32'd1);
        tick();
        idle_in();
        tick();

        // Random traffic, mostly protocol-correct WLAST with occasional violations.
        for (int c = 0; c < 3000; c++) begin
            awPush  = ($urandom_range(0, 99) < 35);
            awSrc   = LOG_N'($urandom_range(0, N - 1));
            awDst   = LOG_M'($urandom_range(0, M - 1));
            awLen   = 8'($urandom_range(0, 5));
            wVld    = N'($urandom);
            busWRdy = ($urandom_range(0, 99) < 70);
            wLast   = N'($urandom);
            if (m_act) begin
                wLast[mq[0].src] = ($urandom_range(0, 99) < 92) ? (m_rem == 1)
                                                                : 1'($urandom_range(0, 1));
            end
            tick();
        end
        idle_in();
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
